uart_num_parser: RTL and testbench
==================================

UART_NUM_PARSER -- requirements
Module: uart_num_parser

Interface
REQ-001 SHALL have parameter DATA_W, default 8; width of the emitted number.
REQ-002 SHALL have parameter MAX_DIGITS, default 3; maximum digits accepted per token.
REQ-003 SHALL have port clk, input, 1; the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1; synchronous active-low reset.
REQ-005 SHALL have port clr, input, 1; synchronous flush of the partial token (from the system FSM on mode change).
REQ-006 SHALL have port rx_valid, input, 1; one-cycle strobe from the UART receiver that a byte is available.
REQ-007 SHALL have port rx_data, input, 8; the received ASCII byte, valid only while rx_valid=1.
REQ-008 SHALL have port num_valid, output, 1; one-cycle strobe that a number has been parsed.
REQ-009 SHALL have port num_value, output, DATA_W; the parsed unsigned value, held until the next num_valid.
REQ-010 SHALL have port num_ovf, output, 1; qualifies num_value as saturated; valid with num_valid.
REQ-011 SHALL have port char_err, output, 1; one-cycle strobe on an illegal character.
REQ-012 SHALL have port busy, output, 1; high while a token is partially accumulated.

Function
REQ-013 Character classes SHALL be:
- digit: 0x30..0x39;
- delimiter: 0x20, 0x0D, 0x0A;
- illegal: any other byte.
REQ-014 The FSM SHALL have three states:
- S_IDLE: no token in progress;
- S_NUM: accumulating a token;
- S_SKIP: discarding a bad token.
REQ-015 S_IDLE: a digit SHALL load acc=digit and cnt=1, then go to S_NUM; a delimiter SHALL be ignored; an illegal byte SHALL pulse char_err and go to S_SKIP.
REQ-016 S_NUM, digit: acc SHALL become acc*10+digit, computed as (acc<<3)+(acc<<1)+digit, and cnt SHALL increment.
REQ-017 S_NUM, delimiter: the block SHALL emit the token and return to S_IDLE.
REQ-018 S_NUM, illegal byte: the block SHALL pulse char_err, emit nothing, and go to S_SKIP.
REQ-019 S_SKIP SHALL discard bytes until a delimiter, then go to S_IDLE; further illegal bytes SHALL pulse char_err again.
REQ-020 Latency: num_valid SHALL assert exactly one clk after the cycle in which the delimiter rx_valid is sampled; char_err SHALL likewise assert one clk after the illegal byte is sampled.
REQ-021 acc SHALL be DATA_W+4 bits wide. A sticky per-token flag ovf SHALL be set when acc exceeds 2^DATA_W-1 or when cnt would exceed MAX_DIGITS. Once ovf is set, further digits SHALL be consumed without changing acc.
REQ-022 On emit, num_value SHALL be {DATA_W{1'b1}} if ovf=1, else acc[DATA_W-1:0]; num_ovf SHALL equal ovf.
REQ-023 A leading zero SHALL be legal ("007" yields 7) and SHALL count toward MAX_DIGITS.
REQ-024 clr=1 SHALL force S_IDLE, acc=0, cnt=0, ovf=0, and suppress num_valid and char_err that cycle. clr SHALL have priority over a simultaneous rx_valid, whose byte is dropped.
REQ-025 rx_valid on consecutive clks SHALL be processed one byte per clk with no loss.
REQ-026 busy SHALL be 1 exactly when the state is S_NUM.

Reset
REQ-027 rst_n=0 at a rising clk edge SHALL set: state=S_IDLE, acc=0, cnt=0, ovf=0, num_valid=0, num_value=0, num_ovf=0, char_err=0, busy=0.
REQ-028 Reset mid-token SHALL discard the partial token; no num_valid SHALL follow.
REQ-029 The first byte after reset release SHALL be parsed normally.

Structure
REQ-030 The ASCII constants (digit range, space, CR, LF) and the state encodings SHALL live in the shared calc package as localparams.
REQ-031 The block SHALL be a single module with no sub-modules. Character classification SHALL be combinational inside it.

Verification
REQ-032 Bytes "2 3 " -> num_valid twice, values 2 then 3, num_ovf=0.
REQ-033 Bytes "12\r\n" -> one num_valid, value 12; CR and LF produce nothing extra.
REQ-034 Bytes "300 " with DATA_W=8 -> value 255, num_ovf=1. Bytes "1234 " -> value 255, num_ovf=1 (exceeds MAX_DIGITS).
REQ-035 Bytes "4x5 7 " -> char_err once, no value for "4x5", then value 7.
REQ-036 "9" then clr, then "8 " -> single num_valid with value 8. The same sequence with rst_n pulsed low instead of clr -> same result.
REQ-037 rx_valid on back-to-back clks for "0 255 " -> values 0 then 255, num_ovf=0, each num_valid exactly 1 clk after its delimiter.

Source files
------------

// File: rtl/uart_num_parser_pkg.sv
// Shared ASCII constants and parser state encodings for the UART number parser.
package uart_num_parser_pkg;

  localparam logic [7:0] ASCII_DIGIT_LO = 8'h30;
  localparam logic [7:0] ASCII_DIGIT_HI = 8'h39;
  localparam logic [7:0] ASCII_SPACE    = 8'h20;
  localparam logic [7:0] ASCII_CR       = 8'h0D;
  localparam logic [7:0] ASCII_LF       = 8'h0A;

  localparam logic [1:0] ST_IDLE_ENC = 2'd0;
  localparam logic [1:0] ST_NUM_ENC  = 2'd1;
  localparam logic [1:0] ST_SKIP_ENC = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE_ENC,
    S_NUM  = ST_NUM_ENC,
    S_SKIP = ST_SKIP_ENC
  } state_t;

endpackage

// File: rtl/uart_num_parser.sv
// Parses space/CR/LF delimited decimal tokens from a UART byte stream into
// unsigned numbers, saturating on value or digit-count overflow.
module uart_num_parser
  import uart_num_parser_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int MAX_DIGITS = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              num_valid,
  output logic [DATA_W-1:0] num_value,
  output logic              num_ovf,
  output logic              char_err,
  output logic              busy
);

  localparam int ACC_W = DATA_W + 4;
  localparam int CNT_W = (MAX_DIGITS < 1) ? 1 : $clog2(MAX_DIGITS + 1);
  localparam logic [ACC_W-1:0] ACC_MAX  = {4'b0000, {DATA_W{1'b1}}};
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_DIGITS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t            state_r;
  logic [ACC_W-1:0]  acc_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              ovf_r;
  logic              num_valid_r;
  logic [DATA_W-1:0] num_value_r;
  logic              num_ovf_r;
  logic              char_err_r;
  logic              busy_r;

  logic              is_digit_s;
  logic              is_delim_s;
  logic [ACC_W-1:0]  digit_s;
  logic [ACC_W-1:0]  acc_next_s;
  logic              acc_too_big_s;
  logic              digit_too_big_s;
  logic              cnt_full_s;

  // Byte classification and the next decimal accumulation step.
  always_comb begin
    is_digit_s      = (rx_data >= ASCII_DIGIT_LO) && (rx_data <= ASCII_DIGIT_HI);
    is_delim_s      = (rx_data == ASCII_SPACE) || (rx_data == ASCII_CR) ||
                      (rx_data == ASCII_LF);
    digit_s         = {{(ACC_W-4){1'b0}}, rx_data[3:0]};
    // acc stays below 2^DATA_W before this step, so x10+9 fits in ACC_W bits
    acc_next_s      = (acc_r << 3) + (acc_r << 1) + digit_s;
    acc_too_big_s   = (acc_next_s > ACC_MAX);
    digit_too_big_s = (digit_s > ACC_MAX);
    cnt_full_s      = (cnt_r >= CNT_MAX);
  end

  // Parser FSM with all outputs registered; clr outranks an incoming byte.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      acc_r       <= {ACC_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      ovf_r       <= 1'b0;
      num_valid_r <= 1'b0;
      num_value_r <= {DATA_W{1'b0}};
      num_ovf_r   <= 1'b0;
      char_err_r  <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      num_valid_r <= 1'b0;
      char_err_r  <= 1'b0;
      if (clr) begin
        state_r <= S_IDLE;
        acc_r   <= {ACC_W{1'b0}};
        cnt_r   <= {CNT_W{1'b0}};
        ovf_r   <= 1'b0;
        busy_r  <= 1'b0;
      end else if (rx_valid) begin
        case (state_r)
          S_IDLE: begin
            if (is_digit_s) begin
              acc_r   <= digit_s;
              cnt_r   <= CNT_ONE;
              ovf_r   <= digit_too_big_s;
              state_r <= S_NUM;
              busy_r  <= 1'b1;
            end else if (!is_delim_s) begin
              char_err_r <= 1'b1;
              state_r    <= S_SKIP;
              busy_r     <= 1'b0;
            end
          end
          S_NUM: begin
            if (is_digit_s) begin
              // once saturated, remaining digits are swallowed unchanged
              if (!ovf_r) begin
                if (cnt_full_s) begin
                  ovf_r <= 1'b1;
                end else begin
                  acc_r <= acc_next_s;
                  cnt_r <= cnt_r + CNT_ONE;
                  ovf_r <= acc_too_big_s;
                end
              end
            end else if (is_delim_s) begin
              num_valid_r <= 1'b1;
              num_value_r <= ovf_r ? {DATA_W{1'b1}} : acc_r[DATA_W-1:0];
              num_ovf_r   <= ovf_r;
              acc_r       <= {ACC_W{1'b0}};
              cnt_r       <= {CNT_W{1'b0}};
              ovf_r       <= 1'b0;
              state_r     <= S_IDLE;
              busy_r      <= 1'b0;
            end else begin
              char_err_r <= 1'b1;
              acc_r      <= {ACC_W{1'b0}};
              cnt_r      <= {CNT_W{1'b0}};
              ovf_r      <= 1'b0;
              state_r    <= S_SKIP;
              busy_r     <= 1'b0;
            end
          end
          S_SKIP: begin
            if (is_delim_s) begin
              state_r <= S_IDLE;
            end else if (!is_digit_s) begin
              char_err_r <= 1'b1;
            end
          end
          default: begin
            state_r <= S_IDLE;
            acc_r   <= {ACC_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            ovf_r   <= 1'b0;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign num_valid = num_valid_r;
  assign num_value = num_value_r;
  assign num_ovf   = num_ovf_r;
  assign char_err  = char_err_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_uart_num_parser.sv
// Scoreboard bench for uart_num_parser: directed byte streams with expected
// numbers/errors queued at issue time and checked by an independent monitor.
module tb_uart_num_parser;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       num_valid;
  logic [7:0] num_value;
  logic       num_ovf;
  logic       char_err;
  logic       busy;

  uart_num_parser #(.DATA_W(8), .MAX_DIGITS(3)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .rx_valid(rx_valid), .rx_data(rx_data),
    .num_valid(num_valid), .num_value(num_value), .num_ovf(num_ovf),
    .char_err(char_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;  // 1 = number, 2 = char error
    int val;
    int ovf;
    int cyc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  bit   gap = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one byte; optionally queue the response expected one clk later.
  task automatic put(input logic [7:0] b, input int kind = 0, input int val = 0,
                     input int ovf = 0);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    if (kind != 0) q.push_back('{kind, val, ovf, cyc + 1});
    if (gap) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  task automatic quiet(input int n);
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Monitor: pop and compare every presented output event.
  always @(negedge clk) begin
    if (num_valid || char_err) begin
      if (q.size() == 0) begin
        check("unexpected_event", {num_valid, char_err}, 0);
      end else begin
        mon_e = q.pop_front();
        check("both_strobes", int'(num_valid && char_err), 0);
        check("event_kind", num_valid ? 1 : 2, mon_e.kind);
        check("event_cycle", cyc, mon_e.cyc);
        if (mon_e.kind == 1) begin
          check("num_value", num_value, mon_e.val);
          check("num_ovf", num_ovf, mon_e.ovf);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; clr = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_num_valid", num_valid, 0);
    check("rst_num_value", num_value, 0);
    check("rst_num_ovf", num_ovf, 0);
    check("rst_char_err", char_err, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;

    // "2 3 "
    put("2"); put(" ", 1, 2, 0); put("3"); put(" ", 1, 3, 0);
    // "12\r\n" with busy tracking
    put("1");
    check("busy_in_token", busy, 1);
    put("2"); put(8'h0D, 1, 12, 0);
    check("busy_after_emit", busy, 0);
    put(8'h0A);
    // saturation by value and by digit count
    put("3"); put("0"); put("0"); put(" ", 1, 255, 1);
    put("1"); put("2"); put("3"); put("4"); put(" ", 1, 255, 1);
    put("2"); put("5"); put("5"); put(" ", 1, 255, 0);
    put("2"); put("5"); put("6"); put(" ", 1, 255, 1);
    put("0"); put("0"); put("7"); put(8'h0A, 1, 7, 0);
    // "4x5 7 "
    put("4"); put("x", 2); put("5");
    check("busy_in_skip", busy, 0);
    put(" "); put("7"); put(" ", 1, 7, 0);
    // repeated illegal bytes while skipping
    put("x", 2); put("y", 2); put("3"); put(" "); put("6"); put(8'h0D, 1, 6, 0);

    // "9", clr, "8 "
    put("9");
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    check("busy_after_clr", busy, 0);
    put("8"); put(" ", 1, 8, 0);
    // clr wins over a simultaneous byte
    @(negedge clk); clr = 1'b1; rx_valid = 1'b1; rx_data = "5";
    @(negedge clk); clr = 1'b0; rx_valid = 1'b0;
    check("busy_clr_drop", busy, 0);
    put(" ");

    // "9", reset pulse, "8 "
    put("9");
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    check("midrst_num_value", num_value, 0);
    check("midrst_busy", busy, 0);
    rst_n = 1'b1;
    put("8"); put(" ", 1, 8, 0);

    // back-to-back "0 255 "
    gap = 1'b0;
    put("0"); put(" ", 1, 0, 0); put("2"); put("5"); put("5"); put(" ", 1, 255, 0);
    quiet(5);
    check("value_hold", num_value, 255);
    check("drain", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
